// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: oData = iData_a - iData_b - iB, borrow out on oData_B.
// Latency: start accepted at edge 0, oDone pulses after edge WIDTH, IDLE again after WIDTH+1.
// Backpressure: none; iStart is only sampled in IDLE and ignored while oBusy is high.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   iStart            request, sampled only in IDLE
//   iData_a/iData_b   minuend / subtrahend, captured on the accept edge
//   iB                borrow in, captured on the accept edge
//   oBusy             high in RUN and DONE
//   oDone             one-cycle pulse, oData/oData_B valid
//   oData, oData_B    difference and final borrow, held until the next oDone
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oData,
  output logic             oData_B
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Holds the WIDTH-1 result bits produced so far; the final bit is
  // merged straight into oData on the last RUN edge.
  logic [WIDTH-2:0] res_sr_q, res_sr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             data_b_q, data_b_d;

  // Full-subtractor cell on the current LSBs.
  logic             a0, b0, d_bit, br_nxt;
  logic [WIDTH-1:0] res_full;

  assign a0       = a_sr_q[0];
  assign b0       = b_sr_q[0];
  assign d_bit    = a0 ^ b0 ^ br_q;
  assign br_nxt   = (~a0 & b0) | (~(a0 ^ b0) & br_q);
  // New bit enters at the MSB; dropping the LSB gives the shifted register.
  assign res_full = {d_bit, res_sr_q};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    data_b_d = data_b_q;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          a_sr_d  = iData_a;
          b_sr_d  = iData_b;
          br_d    = iB;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_full[WIDTH-1:1];
        br_d     = br_nxt;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          data_d   = res_full;
          data_b_d = br_nxt;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      data_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      data_b_q <= data_b_d;
    end
  end

  assign oBusy   = (state_q != S_IDLE);
  assign oDone   = (state_q == S_DONE);
  assign oData   = data_q;
  assign oData_B = data_b_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         iStart = 1'b0;
  logic         iB = 1'b0;
  logic [W-1:0] iData_a = '0;
  logic [W-1:0] iData_b = '0;
  logic         oBusy, oDone, oData_B;
  logic [W-1:0] oData;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iStart  (iStart),
    .iData_a (iData_a),
    .iData_b (iData_b),
    .iB      (iB),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oData   (oData),
    .oData_B (oData_B)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is a (accept edge, 9-bit a-b-iB) pair.
  // The unit is free again WIDTH+2 edges after an accept; the result
  // appears WIDTH edges after it and is held until the next one.
  int         n = 0;
  int         acc = -100;
  bit         active = 1'b0;
  int         free_at = 0;
  logic [W:0] pend = '0;
  logic [W:0] exp_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  = 1'b0;
      exp_res = '0;
      free_at = n;
    end else begin
      n++;
      if (active && n == acc + W) exp_res = pend;
      if (n >= free_at && iStart) begin
        acc     = n;
        active  = 1'b1;
        pend    = {1'b0, iData_a} - {1'b0, iData_b} - {{W{1'b0}}, iB};
        free_at = n + W + 2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy",   {31'd0, oBusy},   {31'd0, rst_n && active && n <= acc + W});
      chk("m_done",   {31'd0, oDone},   {31'd0, rst_n && active && n == acc + W});
      chk("m_data",   {24'd0, oData},   {24'd0, exp_res[W-1:0]});
      chk("m_borrow", {31'd0, oData_B}, {31'd0, exp_res[W]});
    end
  end

  // Inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // k = number of edges after the accept edge at which oDone is seen.
  task automatic wait_done(output int k, output bit ok);
    ok = 1'b0;
    k  = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (oDone) begin
        k  = i;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no oDone within 30 cycles, required one");
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic eb, input string nm);
    int k;
    bit ok;
    iData_a = a;
    iData_b = b;
    iB      = bin;
    iStart  = 1'b1;
    tick();
    iStart  = 1'b0;
    iData_a = W'($urandom);
    iData_b = W'($urandom);
    iB      = 1'($urandom);
    wait_done(k, ok);
    if (ok) begin
      chk({nm, "_lat"},    k, W);
      chk({nm, "_data"},   {24'd0, oData}, {24'd0, ed});
      chk({nm, "_borrow"}, {31'd0, oData_B}, {31'd0, eb});
    end
    tick();
  endtask

  initial begin
    int  k1, k2, busy_cnt;
    bit  ok, seen;
    logic [W:0] e;
    logic [W-1:0] ra, rb;
    logic rbin;

    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", {31'd0, oBusy}, 0);
    chk("rst_done", {31'd0, oDone}, 0);
    chk("rst_data", {24'd0, oData}, 0);
    chk("rst_borrow", {31'd0, oData_B}, 0);
    rst_n = 1'b1;
    tick();

    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "t1");
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "t2");
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "t3a");
    run_op(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, "t3b");

    // iStart held high: the second accept only happens once IDLE is reached.
    iData_a = 8'h80; iData_b = 8'h01; iB = 1'b0; iStart = 1'b1;
    tick();
    iData_a = 8'h10;
    wait_done(k1, ok);
    if (ok) chk("t4_data1", {24'd0, oData}, 32'h7F);
    wait_done(k2, ok);
    iStart = 1'b0;
    if (ok) begin
      chk("t4_interval", k2 + 1, W + 2);
      chk("t4_data2", {24'd0, oData}, 32'h0F);
    end
    tick();

    // Operand changes and a start pulse during RUN must be ignored.
    iData_a = 8'h40; iData_b = 8'h01; iB = 1'b0; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (oBusy) busy_cnt++;
      if (oDone) chk("t5_data", {24'd0, oData}, 32'h3F);
      if (k == 3) begin
        iData_a = 8'hAA; iData_b = 8'h55; iStart = 1'b1;
      end
      if (k == 4) iStart = 1'b0;
    end
    chk("t5_busy_cycles", busy_cnt, W + 1);
    tick();

    // Reset in the middle of RUN aborts the operation.
    iData_a = 8'h77; iData_b = 8'h11; iB = 1'b0; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_busy", {31'd0, oBusy}, 0);
    chk("t6_done", {31'd0, oDone}, 0);
    chk("t6_data", {24'd0, oData}, 0);
    chk("t6_borrow", {31'd0, oData_B}, 0);
    #1;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (oDone) seen = 1'b1;
    end
    chk("t6_no_done", {31'd0, seen}, 0);
    tick();
    run_op(8'h09, 8'h09, 1'b0, 8'h00, 1'b0, "t6b");

    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      e    = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      run_op(ra, rb, rbin, e[W-1:0], e[W], "rnd");
      repeat ($urandom_range(0, 1)) tick();
    end

    repeat (3) tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
